// File: rtl/matrix_arb_pkg.sv
// rtl/matrix_arb_pkg.sv - shared state type, requester indices and default widths for the matrix write arbiter
package matrix_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_STREAM,
    S_DONE,
    S_ABORT
  } arb_state_t;

  localparam int REQ_INPUT     = 0;
  localparam int REQ_GENERATOR = 1;
  localparam int REQ_COMPUTE   = 2;

  localparam int DEF_N_REQ          = 3;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 25_000_000;
  localparam int MATRIX_ID_W        = 3;
  localparam int DIM_W              = 8;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - reloadable down-counter that flags expiry when it reaches zero
module arb_watchdog
  import matrix_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] r_count;

  // Counter parks at zero so expiry stays asserted until the next load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RELOAD;
    end else if (load) begin
      r_count <= RELOAD;
    end else if (enable && r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/matrix_write_arbiter.sv
// rtl/matrix_write_arbiter.sv - round-robin arbiter granting one requester at a time access to the matrix storage writer
module matrix_write_arbiter
  import matrix_arb_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req,
  input  logic [N_REQ-1:0][MATRIX_ID_W-1:0]     req_matrix_id,
  input  logic [N_REQ-1:0][DIM_W-1:0]           req_rows,
  input  logic [N_REQ-1:0][DIM_W-1:0]           req_cols,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_data,
  input  logic [N_REQ-1:0]                      req_data_valid,
  output logic [N_REQ-1:0]                      grant,
  output logic [N_REQ-1:0]                      req_done,
  output logic [N_REQ-1:0]                      req_abort,
  output logic                                  write_request,
  input  logic                                  write_ready,
  output logic [MATRIX_ID_W-1:0]                matrix_id,
  output logic [DIM_W-1:0]                      actual_rows,
  output logic [DIM_W-1:0]                      actual_cols,
  output logic [DATA_WIDTH-1:0]                 data_in,
  output logic                                  data_valid,
  input  logic                                  write_done,
  output logic                                  busy
);

  localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [N_REQ-1:0] r_grant;

  logic             w_active;
  logic             w_stream;
  logic             w_load;
  logic             w_expired;
  logic             w_win_found;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_cand;
  int               w_sum;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  // Scan offsets from the far end so the requester closest to rr_ptr wins
  always_comb begin
    w_sum       = 0;
    w_cand      = '0;
    w_win_found = 1'b0;
    w_win_idx   = r_rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = int'(r_rr_ptr) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_cand = IDX_W'(w_sum);
      if (req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_active = (r_state == S_REQUEST) || (r_state == S_STREAM);
  assign w_stream = (r_state == S_STREAM);
  assign w_load   = !w_active
                  || ((r_state == S_REQUEST) && write_ready)
                  || (w_stream && req_data_valid[r_owner]);

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .enable (w_active),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_owner <= w_win_idx;
            r_grant <= ONE_HOT << w_win_idx;
            r_state <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          // A withdrawn request ends quietly and keeps the rotation where it was
          if (!req[r_owner]) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (write_ready) begin
            r_state <= S_STREAM;
          end else if (w_expired) begin
            r_state <= S_ABORT;
          end
        end
        S_STREAM: begin
          if (write_done) begin
            r_state <= S_DONE;
          end else if (w_expired || !req[r_owner]) begin
            r_state <= S_ABORT;
          end
        end
        S_DONE, S_ABORT: begin
          r_rr_ptr <= next_idx(r_owner);
          r_grant  <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant         = r_grant;
  assign busy          = (r_state != S_IDLE);
  assign write_request = (r_state == S_REQUEST);
  assign req_done      = (r_state == S_DONE)  ? r_grant : '0;
  assign req_abort     = (r_state == S_ABORT) ? r_grant : '0;
  assign matrix_id     = w_active ? req_matrix_id[r_owner] : '0;
  assign actual_rows   = w_active ? req_rows[r_owner]      : '0;
  assign actual_cols   = w_active ? req_cols[r_owner]      : '0;
  assign data_in       = w_stream ? req_data[r_owner]      : '0;
  assign data_valid    = w_stream && req_data_valid[r_owner];

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// tb/tb_matrix_write_arbiter.sv - randomized self-checking bench for matrix_write_arbiter
module tb_matrix_write_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N-1:0][2:0]    req_matrix_id;
  logic [N-1:0][7:0]    req_rows;
  logic [N-1:0][7:0]    req_cols;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_data_valid;
  logic [N-1:0]         grant;
  logic [N-1:0]         req_done;
  logic [N-1:0]         req_abort;
  logic                 write_request;
  logic                 write_ready;
  logic [2:0]           matrix_id;
  logic [7:0]           actual_rows;
  logic [7:0]           actual_cols;
  logic [DW-1:0]        data_in;
  logic                 data_valid;
  logic                 write_done;
  logic                 busy;

  int n_total = 0;
  int n_bad   = 0;
  int m_rr;
  int beats_seen;
  int who;
  int n_wait;
  logic saw_abort;

  matrix_write_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_matrix_id(req_matrix_id),
    .req_rows(req_rows), .req_cols(req_cols), .req_data(req_data),
    .req_data_valid(req_data_valid), .grant(grant), .req_done(req_done),
    .req_abort(req_abort), .write_request(write_request), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .data_in(data_in), .data_valid(data_valid), .write_done(write_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first pending index at or after the rotation pointer
  function automatic int pick(input logic [N-1:0] pend, input int rr);
    for (int k = 0; k < N; k++)
      if (pend[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start(input logic [N-1:0] add, output int w);
    req = req | add;
    w   = pick(req, m_rr);
    step();
  endtask

  // One STREAM cycle: noisy non-owner strobes, owner strobe as given, late requests raised
  task automatic drive_cycle(input int w, input logic own);
    logic [N-1:0] v;
    v    = N'($urandom);
    v[w] = own;
    req_data_valid = v;
    for (int i = 0; i < N; i++) req_data[i] = $urandom;
    if ($urandom_range(7) == 0) req[$urandom_range(N-1)] = 1'b1;
    #1;
    check("dv_owner_only", data_valid, own);
    if (own) check("data_in_mux", data_in, req_data[w]);
    beats_seen += int'(data_valid);
    step();
  endtask

  task automatic grant_phase(input int w, input int dly);
    check("grant", grant, oh(w));
    check("write_request", write_request, 1);
    check("matrix_id", matrix_id, req_matrix_id[w]);
    check("rows", actual_rows, req_rows[w]);
    check("cols", actual_cols, req_cols[w]);
    req_data_valid = '1;
    #1;
    check("dv_in_request", data_valid, 0);
    req_data_valid = '0;
    repeat (dly) begin
      step();
      check("wr_req_hold", write_request, 1);
    end
    write_ready = 1'b1;
    step();
    write_ready = 1'b0;
    check("stream_wr_req", write_request, 0);
    check("stream_busy", busy, 1);
  endtask

  task automatic finish_done(input int w);
    req_data_valid = '0;
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    check("req_done", req_done, oh(w));
    check("done_no_abort", req_abort, 0);
    req[w] = 1'b0;
    m_rr = (w + 1) % N;
    step();
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("done_one_cycle", req_done, 0);
    check("idle_matrix_id", matrix_id, 0);
  endtask

  task automatic abort_end(input int w);
    check("req_abort", req_abort, oh(w));
    check("abort_no_done", req_done, 0);
    req[w] = 1'b0;
    req_data_valid = '0;
    m_rr = (w + 1) % N;
    step();
    check("abort_idle_busy", busy, 0);
    check("abort_one_cycle", req_abort, 0);
  endtask

  task automatic random_write(input int w, input int nb);
    grant_phase(w, $urandom_range(3));
    beats_seen = 0;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(8)) drive_cycle(w, 1'b0);
      drive_cycle(w, 1'b1);
    end
    repeat ($urandom_range(8)) drive_cycle(w, 1'b0);
    check("beat_count", beats_seen, nb);
    finish_done(w);
  endtask

  initial begin
    #500_000;
    $display("FAIL sim_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; req_data_valid = '0; req_data = '0;
    write_ready = 1'b0; write_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_matrix_id[i] = 3'($urandom);
      req_rows[i]      = 8'($urandom_range(255, 1));
      req_cols[i]      = 8'($urandom_range(255, 1));
    end
    m_rr = 0;
    repeat (2) step();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_req", write_request, 0);
    check("rst_dv", data_valid, 0);
    check("rst_done", req_done, 0);
    check("rst_abort", req_abort, 0);
    rst = 1'b0;
    step();

    // Single requester, four beats
    start(3'b010, who);
    grant_phase(who, 2);
    beats_seen = 0;
    repeat (4) begin
      drive_cycle(who, 1'b1);
      drive_cycle(who, 1'b0);
    end
    check("single_beats", beats_seen, 4);
    finish_done(who);

    // Contention from a fresh rotation pointer
    req = '0;
    rst = 1'b1; step(); rst = 1'b0; m_rr = 0;
    step();
    for (int t = 0; t < 3; t++) begin
      start((t == 0) ? 3'b111 : 3'b000, who);
      random_write(who, $urandom_range(3, 1));
    end

    // Watchdog expiry with another requester waiting
    req = '0;
    start(3'b101, who);
    grant_phase(who, 1);
    n_wait = 0;
    while (req_abort == '0 && n_wait < 40) begin
      drive_cycle(who, 1'b0);
      n_wait++;
    end
    check("timeout_latency", n_wait, 17);
    abort_end(who);
    start(3'b000, who);
    random_write(who, 2);

    // Beats every ten cycles keep the watchdog fed
    start(3'($urandom_range(7, 1)), who);
    grant_phase(who, 0);
    saw_abort = 1'b0;
    beats_seen = 0;
    for (int i = 0; i < 100; i++) begin
      saw_abort |= |req_abort;
      drive_cycle(who, (i % 10) == 9);
    end
    check("reload_no_abort", saw_abort, 0);
    check("reload_beats", beats_seen, 10);
    finish_done(who);

    // write_done lands in the same cycle the timer reaches zero
    start(3'($urandom_range(7, 1)), who);
    grant_phase(who, 0);
    repeat (16) drive_cycle(who, 1'b0);
    finish_done(who);

    // Owner abandons mid-stream
    start(3'($urandom_range(7, 1)), who);
    grant_phase(who, 1);
    drive_cycle(who, 1'b1);
    req[who] = 1'b0;
    req_data_valid = '0;
    step();
    abort_end(who);

    // Withdrawal while waiting for write_ready
    start(3'($urandom_range(7, 1)), who);
    check("withdraw_grant", grant, oh(who));
    req[who] = 1'b0;
    step();
    check("withdraw_busy", busy, 0);
    check("withdraw_no_done", req_done, 0);
    check("withdraw_no_abort", req_abort, 0);

    // Randomized traffic
    for (int t = 0; t < 8; t++) begin
      start(3'($urandom_range(7, 1)), who);
      random_write(who, $urandom_range(5, 1));
    end

    // Reset in the middle of a stream clears the rotation pointer
    req = '0;
    step();
    start(3'b001, who);
    random_write(who, 1);
    req = '0;
    start(3'b010, who);
    grant_phase(who, 0);
    drive_cycle(who, 1'b1);
    req_data_valid[who] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_grant", grant, 0);
    check("rst_async_wr_req", write_request, 0);
    check("rst_async_dv", data_valid, 0);
    m_rr = 0;
    step();
    rst = 1'b0;
    req_data_valid = '0;
    check("rst_no_done", req_done, 0);
    check("rst_no_abort", req_abort, 0);
    start(3'b111, who);
    check("rst_no_done_after", req_done, 0);
    random_write(who, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_write_arbiter.md
MATRIX_WRITE_ARBITER -- requirements
Module: matrix_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 3; number of requesters (0 = input, 1 = generator, 2 = compute result).
REQ-002 Parameter DATA_WIDTH, default 32; element width.
REQ-003 Parameter TIMEOUT_CYCLES, default 25_000_000 (0.5 s at 50 MHz); watchdog period; counter width = $clog2(TIMEOUT_CYCLES+1).
REQ-004 Ports, clock and reset first:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester write request, level.
- req_matrix_id  in  N_REQ x 3  target matrix slot.
- req_rows  in  N_REQ x 8  row count.
- req_cols  in  N_REQ x 8  column count.
- req_data  in  N_REQ x DATA_WIDTH  element data.
- req_data_valid  in  N_REQ  element strobe.
- grant  out  N_REQ  one-hot owner of the storage writer.
- req_done  out  N_REQ  one-cycle write-complete pulse.
- req_abort  out  N_REQ  one-cycle watchdog/abandon pulse.
- write_request  out  1  storage write-start request.
- write_ready  in  1  storage accepts the request.
- matrix_id  out  3  muxed slot.
- actual_rows  out  8  muxed rows.
- actual_cols  out  8  muxed cols.
- data_in  out  DATA_WIDTH  muxed data.
- data_valid  out  1  muxed strobe.
- write_done  in  1  storage write finished.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 FSM states: IDLE, REQUEST, STREAM, DONE, ABORT.
REQ-006 IDLE: if any req bit is high, select the winner round-robin starting at rr_ptr, register the one-hot grant, load the timer, and go to REQUEST; else stay.
REQ-007 REQUEST: write_request = 1; on write_ready = 1 go to STREAM; if req[owner] falls, go to IDLE with no pulse.
REQ-008 STREAM: data_valid = req_data_valid[owner], data_in = req_data[owner]; on write_done = 1 go to DONE.
REQ-009 matrix_id, actual_rows and actual_cols shall follow the owner in REQUEST and STREAM and be 0 otherwise.
REQ-010 data_valid shall be 0 outside STREAM; non-owner data_valid shall never propagate.
REQ-011 DONE: req_done[owner] = 1 for exactly one cycle, then IDLE.
REQ-012 ABORT: req_abort[owner] = 1 for exactly one cycle, then IDLE.
REQ-013 Both DONE and ABORT shall set rr_ptr to (owner+1) mod N_REQ and clear grant on IDLE entry.
REQ-014 Watchdog: in REQUEST and STREAM the timer decrements each cycle and reloads to TIMEOUT_CYCLES on every owner data_valid beat or write_ready.
REQ-015 Watchdog expiry: timer == 0 in REQUEST or STREAM shall go to ABORT.
REQ-016 Owner abandon: req[owner] = 0 during STREAM shall go to ABORT on the next cycle.
REQ-017 Simultaneous events: write_done has priority over timeout and over a falling req in the same cycle (go to DONE).
REQ-018 Grant latency: grant is asserted 1 cycle after req rises in IDLE; write_request is high in the same cycle as grant.
REQ-019 Requests arriving while busy are held pending; they are never lost and never preempt the current owner.

Reset
REQ-020 rst shall asynchronously force IDLE, rr_ptr = 0, timer = TIMEOUT_CYCLES, and all outputs to 0.
REQ-021 rst asserted mid-STREAM shall drop write_request and data_valid immediately, with no req_done or req_abort pulse.

Structure
REQ-022 Package matrix_arb_pkg shall hold the state enum arb_state_t, the requester index constants, and the default widths.
REQ-023 The watchdog counter shall be a sub-module arb_watchdog (inputs: load, enable; output: expired), reusable by input_subsystem.

Verification
REQ-024 Single requester: req[1] high, write_ready after 2 cycles, 4 data beats, write_done -> grant = 3'b010 next cycle, 4 data_valid pulses out, req_done[1] pulse.
REQ-025 Contention: req = 3'b111 from IDLE with rr_ptr = 0 -> grant order 0, 1, 2 over three completed writes; rr_ptr ends at 0.
REQ-026 Timeout: TIMEOUT_CYCLES = 16, owner sends no beats after write_ready -> req_abort pulse exactly 17 cycles later; IDLE; next pending requester granted.
REQ-027 Beats reload the timer: TIMEOUT_CYCLES = 16, one beat every 10 cycles for 100 cycles -> no abort.
REQ-028 Same-cycle collision: write_done and timer expiry in the same cycle -> req_done pulses and req_abort stays 0.
REQ-029 Reset mid-STREAM: rst pulse -> busy = 0 and grant = 0 asynchronously; no done/abort pulse; the next req is granted from index 0.
